instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the R-type datapath: owns the PC, issues reads to a

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect/halt control and
// the valid/ready instruction stream towards the datapath.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic [31:0]       tr;
    logic [ADDR_W-1:0] tr_pc;
    logic              tr_valid;
    logic              tr_ready;

    modport master (
        output imem_req, imem_addr, tr, tr_pc, tr_valid,
        input  imem_data, redirect, redirect_pc, halt, tr_ready
    );

    modport slave (
        input  imem_req, imem_addr, tr, tr_pc, tr_valid,
        output imem_data, redirect, redirect_pc, halt, tr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem and queues
// returned words for the datapath, with redirect/flush and halt.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       QDEPTH   = 2
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_unit_if.master  bus
);
    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;

    logic [31:0]       q_data [QDEPTH];
    logic [ADDR_W-1:0] q_pc   [QDEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              not_empty;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occ;

    assign not_empty = (count != '0);
    assign pop       = not_empty && bus.tr_ready;
    // A word returning in a redirect cycle belongs to the old path and is dropped.
    assign push      = vld_p1 && !bus.redirect;
    assign occ       = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    assign issue     = !rst && !bus.redirect && !bus.halt && (occ < (CNT_W+1)'(QDEPTH));

    // Stage p0: PC and request issue; control state under async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            pc_p0  <= bus.redirect_pc & ~ADDR_W'(3);
            vld_p1 <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            if (issue)
                pc_p0 <= pc_p0 + ADDR_W'(4);
            vld_p1 <= issue;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Stage p1: address of the read in flight, paired with vld_p1
    always_ff @(posedge clk) begin
        if (issue)
            pc_p1 <= pc_p0;
    end

    // Queue storage: data only, qualified by count
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= bus.imem_data;
            q_pc[tail]   <= pc_p1;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_p0;
    assign bus.tr_valid  = not_empty;
    assign bus.tr        = not_empty ? q_data[head] : 32'h0;
    assign bus.tr_pc     = not_empty ? q_pc[head]   : '0;

    // Issue gating must make a push into a full queue without a pop impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(QDEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirect,
// PC wrap, halt and asynchronous mid-stream reset against hand-derived values.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_fetch_unit_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .QDEPTH   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: mem[a>>2] = a + 0x1000, one cycle latency.
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_data <= bus.imem_addr + 32'h1000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, 32'(bus.imem_req), 32'(req));
        if (req)
            chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic chk_head(input string tag, input logic vld, input logic [31:0] pc);
        chk({tag, "_vld"}, 32'(bus.tr_valid), 32'(vld));
        chk({tag, "_pc"}, bus.tr_pc, vld ? pc : 32'h0);
        chk({tag, "_tr"}, bus.tr, vld ? pc + 32'h1000 : 32'h0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt        = 1'b0;
        bus.tr_ready    = 1'b1;
        bus.imem_data   = 32'h0;

        repeat (2) next_cyc();
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk_head("rst", 1'b0, 32'h0);

        // Streaming from RESET_PC with the consumer always ready
        next_cyc(); rst = 1'b0; #1;
        chk_req("s_c0", 1'b1, 32'h0);  chk_head("s_c0", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("s_c1", 1'b1, 32'h4);  chk_head("s_c1", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("s_c2", 1'b1, 32'h8);  chk_head("s_c2", 1'b1, 32'h0);
        next_cyc(); #1;
        chk_req("s_c3", 1'b1, 32'hC);  chk_head("s_c3", 1'b1, 32'h4);
        next_cyc(); #1;
        chk_req("s_c4", 1'b1, 32'h10); chk_head("s_c4", 1'b1, 32'h8);

        // Redirect to 0x43 while 0x10 is in flight and 0xC is at the head
        next_cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'h43; #1;
        chk_req("rd_c0", 1'b0, 32'h0);  chk_head("rd_c0", 1'b1, 32'hC);
        next_cyc(); bus.redirect = 1'b0; #1;
        chk_req("rd_c1", 1'b1, 32'h40); chk_head("rd_c1", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("rd_c2", 1'b1, 32'h44); chk_head("rd_c2", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("rd_c3", 1'b1, 32'h48); chk_head("rd_c3", 1'b1, 32'h40);
        next_cyc(); #1;
        chk_req("rd_c4", 1'b1, 32'h4C); chk_head("rd_c4", 1'b1, 32'h44);

        // Redirect near the top of the address space: PC wraps to 0
        next_cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; #1;
        chk_req("wr_c0", 1'b0, 32'h0);          chk_head("wr_c0", 1'b1, 32'h48);
        next_cyc(); bus.redirect = 1'b0; #1;
        chk_req("wr_c1", 1'b1, 32'hFFFF_FFFC); chk_head("wr_c1", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("wr_c2", 1'b1, 32'h0);         chk_head("wr_c2", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("wr_c3", 1'b1, 32'h4);         chk_head("wr_c3", 1'b1, 32'hFFFF_FFFC);
        chk("wr_tr_value", bus.tr, 32'h0000_0FFC);
        next_cyc(); #1;
        chk_req("wr_c4", 1'b1, 32'h8);         chk_head("wr_c4", 1'b1, 32'h0);
        next_cyc(); #1;
        chk_req("wr_c5", 1'b1, 32'hC);         chk_head("wr_c5", 1'b1, 32'h4);

        // Halt with 0xC in flight: queue drains, no new requests, PC frozen at 0x10
        next_cyc(); bus.halt = 1'b1; #1;
        chk_req("h_c0", 1'b0, 32'h0); chk_head("h_c0", 1'b1, 32'h8);
        next_cyc(); #1;
        chk_req("h_c1", 1'b0, 32'h0); chk_head("h_c1", 1'b1, 32'hC);
        next_cyc(); #1;
        chk_req("h_c2", 1'b0, 32'h0); chk_head("h_c2", 1'b0, 32'h0);
        next_cyc(); bus.halt = 1'b0; #1;
        chk_req("h_c3", 1'b1, 32'h10); chk_head("h_c3", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("h_c4", 1'b1, 32'h14); chk_head("h_c4", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("h_c5", 1'b1, 32'h18); chk_head("h_c5", 1'b1, 32'h10);

        // Stall the consumer with 0x18 in flight, then reset asynchronously mid-cycle
        next_cyc(); bus.tr_ready = 1'b0; #1;
        chk_req("ar_c0", 1'b0, 32'h0); chk_head("ar_c0", 1'b1, 32'h14);
        rst = 1'b1; #1;
        chk("ar_req", 32'(bus.imem_req), 32'h0);
        chk("ar_addr", bus.imem_addr, 32'h0);
        chk_head("ar_now", 1'b0, 32'h0);
        next_cyc(); #1;
        chk("ar_hold_req", 32'(bus.imem_req), 32'h0);
        chk_head("ar_hold", 1'b0, 32'h0);

        // Restart at RESET_PC with back-pressure: exactly two requests, then resume at 8
        next_cyc(); rst = 1'b0; #1;
        chk_req("bp_c0", 1'b1, 32'h0); chk_head("bp_c0", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("bp_c1", 1'b1, 32'h4); chk_head("bp_c1", 1'b0, 32'h0);
        next_cyc(); #1;
        chk_req("bp_c2", 1'b0, 32'h0); chk_head("bp_c2", 1'b1, 32'h0);
        next_cyc(); #1;
        chk_req("bp_c3", 1'b0, 32'h0); chk_head("bp_c3", 1'b1, 32'h0);
        next_cyc(); #1;
        chk_req("bp_c4", 1'b0, 32'h0); chk_head("bp_c4", 1'b1, 32'h0);
        next_cyc(); bus.tr_ready = 1'b1; #1;
        chk_req("bp_c5", 1'b1, 32'h8);  chk_head("bp_c5", 1'b1, 32'h0);
        next_cyc(); #1;
        chk_req("bp_c6", 1'b1, 32'hC);  chk_head("bp_c6", 1'b1, 32'h4);
        next_cyc(); #1;
        chk_req("bp_c7", 1'b1, 32'h10); chk_head("bp_c7", 1'b1, 32'h8);
        next_cyc(); #1;
        chk_req("bp_c8", 1'b1, 32'h14); chk_head("bp_c8", 1'b1, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
